// File: rtl/pong_game_sequencer.sv
// Pong game-flow controller: idle, serve countdown, live play, point freeze and game over.
// Optional macro PONG_AUTO_SERVE_EN: serve starts on countdown expiry without waiting for the button.
module pong_game_sequencer #(
  parameter int WIN_SCORE    = 9,
  parameter int SCORE_WIDTH  = 4,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 30
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_Frame_Tick,
  input  logic                   i_Miss_Left,
  input  logic                   i_Miss_Right,
  input  logic                   i_Serve,
  output logic                   o_Ball_Center,
  output logic                   o_Ball_Enable,
  output logic                   o_Serve_HDir,
  output logic                   o_Serve_VDir,
  output logic [SCORE_WIDTH-1:0] o_Score_P1,
  output logic [SCORE_WIDTH-1:0] o_Score_P2,
  output logic [2:0]             o_State,
  output logic                   o_Game_Over,
  output logic                   o_Winner
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SERVE     = 3'd1;
  localparam logic [2:0] ST_PLAY      = 3'd2;
  localparam logic [2:0] ST_POINT     = 3'd3;
  localparam logic [2:0] ST_GAME_OVER = 3'd4;

  localparam int MAX_FRAMES = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int CNT_WIDTH  = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;

  localparam logic [CNT_WIDTH-1:0]   SERVE_LOAD = CNT_WIDTH'(SERVE_FRAMES - 1);
  localparam logic [CNT_WIDTH-1:0]   POINT_LOAD = CNT_WIDTH'(POINT_FRAMES - 1);
  localparam logic [SCORE_WIDTH-1:0] WIN_VAL    = SCORE_WIDTH'(WIN_SCORE);

`ifdef PONG_AUTO_SERVE_EN
  localparam bit AUTO_SERVE = 1'b1;
`else
  localparam bit AUTO_SERVE = 1'b0;
`endif

  generate
    if (WIN_SCORE < 1 || WIN_SCORE >= (1 << SCORE_WIDTH) || SERVE_FRAMES < 1 || POINT_FRAMES < 1)
    begin : g_param_error
      $error("pong_game_sequencer: WIN_SCORE must fit in SCORE_WIDTH and frame counts must be >= 1");
    end
  endgenerate

  logic [2:0]             state_reg, state_next;
  logic [CNT_WIDTH-1:0]   cnt_reg, cnt_next;
  logic                   armed_reg, armed_next;
  logic                   seen_low_reg, seen_low_next;
  logic [SCORE_WIDTH-1:0] p1_reg, p1_next;
  logic [SCORE_WIDTH-1:0] p2_reg, p2_next;
  logic                   center_reg, center_next;
  logic                   enable_reg, enable_next;
  logic                   hdir_reg, hdir_next;
  logic                   vdir_reg, vdir_next;
  logic                   game_over_reg, game_over_next;
  logic                   winner_reg, winner_next;

  logic tick_expire;
  logic go_play;
  logic scored;
  logic score_wins;
  logic scorer;

  assign tick_expire = i_Frame_Tick && (cnt_reg == '0);

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    armed_next     = armed_reg;
    seen_low_next  = seen_low_reg;
    p1_next        = p1_reg;
    p2_next        = p2_reg;
    center_next    = center_reg;
    enable_next    = enable_reg;
    hdir_next      = hdir_reg;
    vdir_next      = vdir_reg;
    game_over_next = game_over_reg;
    winner_next    = winner_reg;
    go_play        = 1'b0;
    scored         = 1'b0;
    score_wins     = 1'b0;
    scorer         = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        p1_next = '0;
        p2_next = '0;
        if (i_Serve) begin
          state_next = ST_SERVE;
          cnt_next   = SERVE_LOAD;
          armed_next = 1'b0;
        end
      end

      ST_SERVE: begin
        if (i_Frame_Tick && (cnt_reg != '0)) cnt_next = cnt_reg - 1'b1;
        // Once expired, the counter rests at 0 and armed remembers it for the button gate.
        if (tick_expire) armed_next = 1'b1;
        if (AUTO_SERVE) go_play = tick_expire;
        else            go_play = (tick_expire || armed_reg) && i_Serve;
        if (go_play) begin
          state_next  = ST_PLAY;
          center_next = 1'b0;
          enable_next = 1'b1;
        end
      end

      ST_PLAY: begin
        if (i_Miss_Left) begin
          scored     = 1'b1;
          scorer     = 1'b1;
          p2_next    = p2_reg + 1'b1;
          hdir_next  = 1'b1;
          score_wins = ((p2_reg + 1'b1) == WIN_VAL);
        end else if (i_Miss_Right) begin
          scored     = 1'b1;
          scorer     = 1'b0;
          p1_next    = p1_reg + 1'b1;
          hdir_next  = 1'b0;
          score_wins = ((p1_reg + 1'b1) == WIN_VAL);
        end
        if (scored) begin
          enable_next = 1'b0;
          if (score_wins) begin
            state_next     = ST_GAME_OVER;
            game_over_next = 1'b1;
            winner_next    = scorer;
            seen_low_next  = 1'b0;
          end else begin
            state_next = ST_POINT;
            cnt_next   = POINT_LOAD;
          end
        end
      end

      ST_POINT: begin
        if (tick_expire) begin
          state_next  = ST_SERVE;
          cnt_next    = SERVE_LOAD;
          armed_next  = 1'b0;
          center_next = 1'b1;
          vdir_next   = ~vdir_reg;
        end else if (i_Frame_Tick) begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      ST_GAME_OVER: begin
        // A button still held from the final rally must be released before it restarts the game.
        if (!i_Serve) begin
          seen_low_next = 1'b1;
        end else if (seen_low_reg) begin
          state_next     = ST_IDLE;
          p1_next        = '0;
          p2_next        = '0;
          center_next    = 1'b1;
          game_over_next = 1'b0;
          winner_next    = 1'b0;
        end
      end

      default: begin
        state_next     = ST_IDLE;
        p1_next        = '0;
        p2_next        = '0;
        center_next    = 1'b1;
        enable_next    = 1'b0;
        game_over_next = 1'b0;
        winner_next    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      armed_reg     <= 1'b0;
      seen_low_reg  <= 1'b0;
      p1_reg        <= '0;
      p2_reg        <= '0;
      center_reg    <= 1'b1;
      enable_reg    <= 1'b0;
      hdir_reg      <= 1'b0;
      vdir_reg      <= 1'b1;
      game_over_reg <= 1'b0;
      winner_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      armed_reg     <= armed_next;
      seen_low_reg  <= seen_low_next;
      p1_reg        <= p1_next;
      p2_reg        <= p2_next;
      center_reg    <= center_next;
      enable_reg    <= enable_next;
      hdir_reg      <= hdir_next;
      vdir_reg      <= vdir_next;
      game_over_reg <= game_over_next;
      winner_reg    <= winner_next;
    end
  end

  assign o_State       = state_reg;
  assign o_Ball_Center = center_reg;
  assign o_Ball_Enable = enable_reg;
  assign o_Serve_HDir  = hdir_reg;
  assign o_Serve_VDir  = vdir_reg;
  assign o_Score_P1    = p1_reg;
  assign o_Score_P2    = p2_reg;
  assign o_Game_Over   = game_over_reg;
  assign o_Winner      = winner_reg;

endmodule

// File: doc/pong_game_sequencer.md
Name: pong_game_sequencer

Overview:
Top-level game-flow controller for the Pong datapath. Sequences the ball through idle, serve countdown, live play, point freeze and game over. Keeps both players' scores and tells the ball/direction logic when to centre, when to move and which direction to serve in. Sits between the frame-timing logic (sync/blank generation) and the ball position and direction blocks.

Parameters:
WIN_SCORE, 9, score value that ends the game (1..2^SCORE_WIDTH-1)
SCORE_WIDTH, 4, width of each score register
SERVE_FRAMES, 60, frame ticks the ball is held centred before a serve
POINT_FRAMES, 30, frame ticks play is frozen after a point

Ports:
i_Clk  input  1  system clock
i_Reset  input  1  synchronous active-high reset
i_Frame_Tick  input  1  one-cycle pulse per video frame (start of vertical blank)
i_Miss_Left  input  1  one-cycle pulse: ball passed the left edge without a paddle hit
i_Miss_Right  input  1  one-cycle pulse: ball passed the right edge without a paddle hit
i_Serve  input  1  serve/start button, level, already debounced
o_Ball_Center  output  1  high: ball position logic holds ball at screen centre
o_Ball_Enable  output  1  high: ball position logic may advance the ball
o_Serve_HDir  output  1  serve horizontal direction (0 = right, 1 = left)
o_Serve_VDir  output  1  serve vertical direction (0 = down, 1 = up)
o_Score_P1  output  SCORE_WIDTH  left player score
o_Score_P2  output  SCORE_WIDTH  right player score
o_State  output  3  current state encoding, for debug/display
o_Game_Over  output  1  high while in GAME_OVER
o_Winner  output  1  valid with o_Game_Over: 0 = P1, 1 = P2

Behaviour:
- Interface: one clock, i_Clk; reset is synchronous and active-high on i_Reset, sampled on the rising edge of i_Clk.
- All outputs are registered. Reset values: state IDLE, both scores 0, o_Ball_Center 1, o_Ball_Enable 0, o_Serve_HDir 0, o_Serve_VDir 1, o_Game_Over 0, o_Winner 0.
- Reset mid-operation from any state: same values on the next edge; any pending countdown is discarded.
- States and o_State encoding: IDLE=0, SERVE=1, PLAY=2, POINT=3, GAME_OVER=4.
- IDLE: Center=1, Enable=0. Scores are held at 0. i_Serve=1 -> SERVE.
- SERVE: Center=1, Enable=0. Frame counter is loaded with SERVE_FRAMES-1 on entry and decrements on each i_Frame_Tick. A tick while the counter is 0 marks expiry. On expiry -> PLAY (see the optional feature for the button gate).
- PLAY: Center=0, Enable=1. Miss inputs are honoured only in PLAY and are ignored in every other state.
  - i_Miss_Left: P2 score +1, o_Serve_HDir <= 1 (next serve goes toward the player who conceded).
  - i_Miss_Right: P1 score +1, o_Serve_HDir <= 0.
  - Both misses in the same cycle: i_Miss_Left wins and i_Miss_Right is dropped.
  - After scoring: if the new score equals WIN_SCORE -> GAME_OVER with o_Winner set to the scorer; otherwise -> POINT.
  - Only one point is scored per rally; PLAY is left on the same edge the miss is taken.
- POINT: Center=0, Enable=0 (ball frozen in place). Counter is loaded with POINT_FRAMES-1 and decrements on each i_Frame_Tick. On expiry -> SERVE and o_Serve_VDir toggles.
- GAME_OVER: Center=0, Enable=0, o_Game_Over=1, scores held.
  - i_Serve=1 -> IDLE with both scores cleared.
  - The transition requires i_Serve to have been seen low at least once since entering GAME_OVER, so a held button cannot skip the end screen.
- Latency: output changes appear on the same edge that commits the state transition; the new state's outputs are visible in the following cycle.
- Scores never wrap, because the game ends at WIN_SCORE. A WIN_SCORE that does not fit in SCORE_WIDTH is a parameter error.
- i_Frame_Tick arriving on the state-entry cycle does not decrement the counter, because the counter is loaded on that edge.
- If SERVE_FRAMES or POINT_FRAMES is 1, the first tick after entry expires the state.

Optional Feature:
PONG_AUTO_SERVE_EN
- Defined: SERVE -> PLAY on counter expiry alone.
- Undefined: on expiry the counter holds at 0 and SERVE waits for i_Serve=1 before moving to PLAY. i_Serve held high during the countdown proceeds on the expiry tick.
- IDLE and GAME_OVER always require i_Serve.

Test Plan:
- Reset, i_Serve pulse, SERVE_FRAMES=4 with auto serve -> PLAY exactly on the 4th i_Frame_Tick; Center falls and Enable rises on the cycle after that tick.
- In PLAY, i_Miss_Left -> P2=1, o_Serve_HDir=1, POINT entered. After POINT_FRAMES ticks -> SERVE with o_Serve_VDir toggled to 0.
- i_Miss_Left and i_Miss_Right in the same cycle -> only P2 increments; a further miss during POINT is ignored and scores are unchanged.
- WIN_SCORE=3, three i_Miss_Right rallies -> after the third: P1=3, GAME_OVER, o_Winner=0. i_Serve held through the transition does not leave GAME_OVER; release then press -> IDLE with both scores 0.
- i_Reset asserted in PLAY with P1=2, P2=1 -> next cycle IDLE, scores 0, Center=1, Enable=0, Serve_VDir=1.
- Without PONG_AUTO_SERVE_EN: countdown expires with i_Serve low -> stays in SERVE for 10 further ticks; i_Serve=1 -> PLAY on the next edge.
